// File: rtl/npu_dot_engine.sv
// npu_dot_engine: serial signed dot-product/accumulate engine.
// A LANES-entry weight register file is loaded over the input stream, then
// activation vectors are streamed through one shared multiplier, one element
// per cycle. After the vector flagged by in_last the accumulator is shifted,
// saturated to DATA_W and presented on a valid/ready output.
// Optional build macro: NPU_RELU_EN (clamp negative results to zero).
module npu_dot_engine #(
    parameter int LANES  = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_load,
    input  logic                     start_run,
    input  logic [3:0]               shift,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     overflow,
    output logic                     busy
);

    localparam int KW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(LANES - 1);
    localparam logic signed [DATA_W-1:0] OUT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] OUT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, LOAD, RUN, SAT, OUT} state_t;

    state_t state, next_state;

    logic [KW-1:0]              k;
    logic signed [DATA_W-1:0]   weight [LANES];
    logic signed [ACC_W-1:0]    acc;
    logic                       last_seen;

    logic                       transfer;
    logic                       lane_end;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    sum;
    logic                       add_ovf;
    logic signed [ACC_W-1:0]    shifted;
    logic signed [ACC_W-1:0]    sat_in;
    logic signed [DATA_W-1:0]   clamped;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state logic and state-decoded handshake outputs
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start_load)     next_state = LOAD;
                else if (start_run) next_state = RUN;
            end
            LOAD: begin
                in_ready = 1'b1;
                if (transfer && lane_end) next_state = IDLE;
            end
            RUN: begin
                in_ready = 1'b1;
                if (transfer && lane_end && (last_seen || in_last)) next_state = SAT;
            end
            SAT: next_state = OUT;
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Multiply-accumulate, overflow detection and requantise/saturate datapath
    always_comb begin
        transfer = in_valid && in_ready;
        lane_end = (k == K_LAST);
        prod     = (2*DATA_W)'(weight[k]) * (2*DATA_W)'(in_data);
        prod_ext = ACC_W'(prod);
        sum      = acc + prod_ext;
        // Signed wrap: both addends share a sign the sum does not.
        add_ovf  = (acc[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
        shifted  = acc >>> shift;
        sat_in   = shifted;
`ifdef NPU_RELU_EN
        if (shifted < 0) sat_in = '0;
`else
        sat_in   = shifted;
`endif
        if (sat_in > ACC_W'(OUT_MAX))      clamped = OUT_MAX;
        else if (sat_in < ACC_W'(OUT_MIN)) clamped = OUT_MIN;
        else                               clamped = sat_in[DATA_W-1:0];
    end

    // Weights, lane counter, accumulator, sticky flags and result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k         <= '0;
            acc       <= '0;
            last_seen <= 1'b0;
            overflow  <= 1'b0;
            out_data  <= '0;
            for (int unsigned i = 0; i < LANES; i++) weight[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!start_load && start_run) begin
                        acc      <= '0;
                        overflow <= 1'b0;
                    end
                end
                LOAD: begin
                    if (transfer) begin
                        weight[k] <= in_data;
                        k         <= lane_end ? '0 : k + 1'b1;
                    end
                end
                RUN: begin
                    if (transfer) begin
                        acc <= sum;
                        k   <= lane_end ? '0 : k + 1'b1;
                        if (add_ovf) overflow  <= 1'b1;
                        if (in_last) last_seen <= 1'b1;
                    end
                end
                SAT: out_data <= clamped;
                OUT: begin
                    if (out_ready) last_seen <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_npu_dot_engine.sv
// Testbench for npu_dot_engine: directed scenarios plus randomized runs,
// all checked against an arithmetic reference model of the dot product.
module tb_npu_dot_engine;

    localparam int LANES  = 4;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 20;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     start_load, start_run;
    logic [3:0]               shift;
    logic                     in_valid, in_ready, in_last;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_valid, out_ready;
    logic signed [DATA_W-1:0] out_data;
    logic                     overflow, busy;

    int errors = 0;
    int checks = 0;

    int wts [LANES];
    int acts [$];

    npu_dot_engine #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .start_load(start_load), .start_run(start_run),
        .shift(shift), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .overflow(overflow),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference: plain arithmetic dot product over all sent elements,
    // wrapped to ACC_W, then floor-divided by 2^sh and clamped.
    function automatic void model_run(input int sh, output int res, output bit ovf);
        longint half, full, a, s, q;
        half = longint'(1) <<< (ACC_W - 1);
        full = half * 2;
        a = 0;
        ovf = 1'b0;
        foreach (acts[i]) begin
            s = a + longint'(wts[i % LANES]) * longint'(acts[i]);
            if (s >= half || s < -half) ovf = 1'b1;
            a = (((s + half) % full) + full) % full - half;
        end
        q = a;
        for (int i = 0; i < sh; i++) q = (q < 0) ? (q - 1) / 2 : q / 2;
`ifdef NPU_RELU_EN
        if (q < 0) q = 0;
`endif
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        res = int'(q);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input bit ld, input bit rn);
        start_load = ld;
        start_run  = rn;
        tick();
        start_load = 1'b0;
        start_run  = 1'b0;
    endtask

    task automatic send(input int d, input bit last, input bit gaps);
        if (gaps) while ($urandom_range(0, 2) == 0) tick();
        in_valid = 1'b1;
        in_data  = DATA_W'(d);
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic load_weights(input bit both);
        pulse_start(1'b1, both);
        for (int i = 0; i < LANES; i++) send(wts[i], 1'b1, both);
    endtask

    // Sends acts; in_last on element lastpos. Returns just after the accept edge.
    task automatic send_run(input int sh, input int lastpos, input bit gaps);
        shift = 4'(sh);
        pulse_start(1'b0, 1'b1);
        foreach (acts[i]) send(acts[i], i == lastpos, gaps);
    endtask

    task automatic wait_out(output bit got);
        got = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (out_valid) begin
                got = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic accept_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic fill_acts(input int nv, input int v);
        acts.delete();
        for (int i = 0; i < nv * LANES; i++) acts.push_back(v);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        checks++;
        if ({in_ready, out_valid, overflow, busy} !== 4'b0 || out_data !== 8'sd0) begin
            errors++;
            $display("FAIL reset_outputs: got in_ready=%b out_valid=%b out_data=%0d overflow=%b busy=%b, want all 0",
                     in_ready, out_valid, out_data, overflow, busy);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got in_ready=%b busy=%b, want 0 0", in_ready, busy);
        end
    endtask

    task automatic test_basic();
        bit got;
        wts = '{1, 2, 3, 4};
        load_weights(1'b0);
        fill_acts(1, 1);
        send_run(0, 3, 1'b0);
        // First sample after the accepting edge: still working, nothing presented.
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_latency_early: got out_valid=%b busy=%b, want 0 1", out_valid, busy);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_latency: got out_valid=%b two edges after final accept, want 1", out_valid);
        end
        wait_out(got);
        checks++;
        if (!got || out_data !== 8'sd10 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: got valid=%b data=%0d ovf=%b, want 1 10 0", got, out_data, overflow);
        end
        accept_out();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_return_idle: got busy=%b out_valid=%b, want 0 0", busy, out_valid);
        end
    endtask

    task automatic test_multi_vector();
        bit got;
        acts = '{10, 10, 10, 10, -5, -5, -5, -5};
        send_run(1, 7, 1'b1);
        wait_out(got);
        checks++;
        if (!got || out_data !== 8'sd25 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL multi_vector: got valid=%b data=%0d ovf=%b, want 1 25 0", got, out_data, overflow);
        end
        accept_out();
    endtask

    task automatic test_saturation();
        bit got;
        logic signed [DATA_W-1:0] exp_neg;
`ifdef NPU_RELU_EN
        exp_neg = 8'sd0;
`else
        exp_neg = -8'sd128;
`endif
        wts = '{127, 127, 127, 127};
        load_weights(1'b0);
        fill_acts(1, 127);
        send_run(0, 3, 1'b0);
        wait_out(got);
        checks++;
        if (!got || out_data !== 8'sd127) begin
            errors++;
            $display("FAIL sat_positive: got valid=%b data=%0d, want 1 127", got, out_data);
        end
        accept_out();
        fill_acts(1, -128);
        send_run(0, 3, 1'b0);
        wait_out(got);
        checks++;
        if (!got || out_data !== exp_neg) begin
            errors++;
            $display("FAIL sat_negative: got valid=%b data=%0d, want 1 %0d", got, out_data, exp_neg);
        end
        accept_out();
    endtask

    task automatic test_overflow();
        bit got;
        logic signed [DATA_W-1:0] exp_d;
`ifdef NPU_RELU_EN
        exp_d = 8'sd0;
`else
        exp_d = -8'sd128;
`endif
        wts = '{-128, -128, -128, -128};
        load_weights(1'b0);
        fill_acts(8, -128);
        send_run(0, 31, 1'b0);
        wait_out(got);
        checks++;
        if (!got || overflow !== 1'b1 || out_data !== exp_d) begin
            errors++;
            $display("FAIL overflow_set: got valid=%b ovf=%b data=%0d, want 1 1 %0d", got, overflow, out_data, exp_d);
        end
        repeat (3) tick();
        checks++;
        if (overflow !== 1'b1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL overflow_held: got ovf=%b valid=%b, want 1 1", overflow, out_valid);
        end
        accept_out();
        pulse_start(1'b0, 1'b1);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clear: got ovf=%b after start_run, want 0", overflow);
        end
        for (int i = 0; i < LANES; i++) send(1, i == LANES - 1, 1'b0);
        wait_out(got);
        accept_out();
    endtask

    task automatic test_backpressure();
        bit got;
        int exp_r;
        bit exp_o;
        logic signed [DATA_W-1:0] held;
        wts = '{3, -7, 11, 2};
        load_weights(1'b0);
        acts = '{20, -9, 5, 40};
        model_run(0, exp_r, exp_o);
        send_run(0, 3, 1'b0);
        wait_out(got);
        held = out_data;
        checks++;
        if (!got || held !== DATA_W'(exp_r)) begin
            errors++;
            $display("FAIL bp_result: got valid=%b data=%0d, want 1 %0d", got, held, exp_r);
        end
        for (int c = 0; c < 5; c++) begin
            start_load = (c == 1);
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got valid=%b data=%0d in_ready=%b, want 1 %0d 0",
                         c, out_valid, out_data, in_ready, held);
            end
        end
        start_load = 1'b0;
        accept_out();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: got busy=%b out_valid=%b, want 0 0", busy, out_valid);
        end
    endtask

    task automatic test_random();
        bit got;
        int exp_r, nv, lane, sh;
        bit exp_o;
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < LANES; i++) wts[i] = $urandom_range(0, 255) - 128;
            // Simultaneous start pulses must select the weight load.
            load_weights(t % 2 == 1);
            nv   = $urandom_range(1, 4);
            lane = $urandom_range(0, LANES - 1);
            sh   = $urandom_range(0, 15);
            acts.delete();
            for (int i = 0; i < nv * LANES; i++) acts.push_back($urandom_range(0, 255) - 128);
            model_run(sh, exp_r, exp_o);
            send_run(sh, (nv - 1) * LANES + lane, 1'b1);
            wait_out(got);
            checks++;
            if (!got || out_data !== DATA_W'(exp_r) || overflow !== exp_o) begin
                errors++;
                $display("FAIL random[%0d]: got valid=%b data=%0d ovf=%b, want 1 %0d %b (nv=%0d sh=%0d)",
                         t, got, out_data, overflow, exp_r, exp_o, nv, sh);
            end
            accept_out();
        end
    endtask

    task automatic test_reset_midrun();
        bit got;
        wts = '{5, 6, 7, 8};
        load_weights(1'b0);
        fill_acts(1, 9);
        send_run(0, 3, 1'b0);
        wait_out(got);
        accept_out();
        pulse_start(1'b0, 1'b1);
        send(3, 1'b0, 1'b0);
        send(4, 1'b0, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid, overflow, busy} !== 4'b0 || out_data !== 8'sd0) begin
            errors++;
            $display("FAIL reset_midrun: got in_ready=%b out_valid=%b out_data=%0d overflow=%b busy=%b, want all 0",
                     in_ready, out_valid, out_data, overflow, busy);
        end
        tick();
        rst = 1'b0;
        tick();
        acts = '{-100, 77, 127, -128};
        send_run(0, 3, 1'b0);
        wait_out(got);
        checks++;
        if (!got || out_data !== 8'sd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL weights_cleared: got valid=%b data=%0d ovf=%b, want 1 0 0", got, out_data, overflow);
        end
        accept_out();
    endtask

    initial begin
        start_load = 1'b0;
        start_run  = 1'b0;
        shift      = 4'd0;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        test_reset();
        test_basic();
        test_multi_vector();
        test_saturation();
        test_overflow();
        test_backpressure();
        test_random();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
